// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared defaults, buffering depths and saturation limits for the multiplier arbiter.
package mul_arb_pkg;
    localparam int DEF_WIDTH     = 14;
    localparam int DEF_FRAC_BITS = 7;
    localparam int FIFO_DEPTH    = 4;
    localparam int PIPE_DEPTH    = 2;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction
endpackage

// File: rtl/fxp_mul_core.sv
// fxp_mul_core: registered signed fixed-point multiply with round-to-nearest-even and saturation.
// MUL_ARB_SAT_FLAG_EN adds the o_sat clamp indicator.
module fxp_mul_core
    import mul_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ID_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic [ID_W-1:0]         i_id,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
`ifdef MUL_ARB_SAT_FLAG_EN
    output logic                    o_sat,
`endif
    output logic [ID_W-1:0]         o_id
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(WIDTH));
    localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(WIDTH));
    localparam logic [FRAC_BITS-1:0] HALF  = FRAC_BITS'(1 << (FRAC_BITS - 1));

    logic signed [PW-1:0] w_prod, w_q, w_r;
    logic [FRAC_BITS-1:0] w_drop;
    logic                 w_up, w_hi, w_lo;
    logic [WIDTH-1:0]     w_res;

    assign w_prod = PW'(i_a) * PW'(i_b);
    assign w_q    = w_prod >>> FRAC_BITS;
    assign w_drop = w_prod[FRAC_BITS-1:0];
    // ties go up only when the truncated value is odd
    assign w_up   = (w_drop > HALF) || (w_drop == HALF && w_q[0]);
    assign w_r    = w_q + PW'(w_up);
    assign w_hi   = w_r > P_MAX;
    assign w_lo   = w_r < P_MIN;
    assign w_res  = w_hi ? WIDTH'(P_MAX) : w_lo ? WIDTH'(P_MIN) : w_r[WIDTH-1:0];

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [ID_W-1:0]  r_id;
`ifdef MUL_ARB_SAT_FLAG_EN
    logic             r_sat;
    assign o_sat = r_sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_res;
                r_id   <= i_id;
`ifdef MUL_ARB_SAT_FLAG_EN
                r_sat  <= w_hi | w_lo;
`endif
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_id    = r_id;
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one fixed-point multiplier with credit-based 4-deep result FIFO.
// MUL_ARB_SAT_FLAG_EN adds rsp_sat, carried through the FIFO with each result.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    localparam int ID_W     = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]            rsp_id,
`ifdef MUL_ARB_SAT_FLAG_EN
    output logic                       rsp_sat,
`endif
    output logic                       busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]    r_ptr, w_gidx;
    logic               w_found, w_credit, w_xfer, w_pop;
    logic [NUM_REQ-1:0] w_grant;
    logic [CNT_W:0]     w_used;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_gidx  = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    logic                    r_iss_v;
    logic [WIDTH-1:0]        r_iss_a, r_iss_b;
    logic [ID_W-1:0]         r_iss_id;
    logic                    w_core_v;
    logic [WIDTH-1:0]        w_core_data;
    logic [ID_W-1:0]         w_core_id;
    logic [CNT_W-1:0]        r_count;
    logic [PTR_W-1:0]        r_wr, r_rd;
    logic [WIDTH-1:0]        r_mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]         r_mem_id   [FIFO_DEPTH];

    // buffered plus in-flight results must always fit in the FIFO
    assign w_used    = {1'b0, r_count} + (CNT_W+1)'(r_iss_v) + (CNT_W+1)'(w_core_v);
    assign w_credit  = w_used < (CNT_W+1)'(FIFO_DEPTH);
    assign w_grant   = NUM_REQ'(w_found) << w_gidx;
    assign req_ready = w_credit ? w_grant : '0;
    assign w_xfer    = |req_ready;
    assign w_pop     = rsp_valid & rsp_ready;

`ifdef MUL_ARB_SAT_FLAG_EN
    logic w_core_sat;
    logic r_mem_sat [FIFO_DEPTH];
`endif

    fxp_mul_core #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .ID_W(ID_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_iss_v),
        .i_a     (r_iss_a),
        .i_b     (r_iss_b),
        .i_id    (r_iss_id),
        .o_valid (w_core_v),
        .o_data  (w_core_data),
`ifdef MUL_ARB_SAT_FLAG_EN
        .o_sat   (w_core_sat),
`endif
        .o_id    (w_core_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_iss_v <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_iss_v <= w_xfer;
            if (w_xfer) begin
                r_ptr    <= ID_W'((int'(w_gidx) + 1) % NUM_REQ);
                r_iss_a  <= req_a[w_gidx*WIDTH +: WIDTH];
                r_iss_b  <= req_b[w_gidx*WIDTH +: WIDTH];
                r_iss_id <= w_gidx;
            end
            if (w_core_v) begin
                r_mem_data[r_wr] <= w_core_data;
                r_mem_id[r_wr]   <= w_core_id;
`ifdef MUL_ARB_SAT_FLAG_EN
                r_mem_sat[r_wr]  <= w_core_sat;
`endif
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop) r_rd <= r_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_core_v) - CNT_W'(w_pop);
        end
    end

    assign rsp_valid = r_count != '0;
    assign rsp_data  = rsp_valid ? r_mem_data[r_rd] : '0;
    assign rsp_id    = rsp_valid ? r_mem_id[r_rd] : '0;
`ifdef MUL_ARB_SAT_FLAG_EN
    assign rsp_sat   = rsp_valid & r_mem_sat[r_rd];
`endif
    assign busy      = r_iss_v | w_core_v | rsp_valid;
endmodule
